// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_slave_pkg;

   localparam int DEF_ADDR_WIDH = 8;
   localparam int DEF_DATA_WIDH = 8;
   localparam int FRAME_W       = DEF_ADDR_WIDH + 2;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_t;

   // Frame bits 9:8 as seen by the RAM; only bit 9 matters for routing here.
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serializer driving MISO; done marks the idle edge after the last bit.
module spi_tx_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] data,
   output logic             MISO,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] shift;
   logic [CW-1:0]    cnt;
   logic             busy;

   // The load edge only captures the word; the first bit appears on the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         MISO  <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         busy  <= 1'b0;
         MISO  <= 1'b0;
      end else if (load) begin
         shift <= data;
         cnt   <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         if (cnt == CW'(WIDTH)) begin
            MISO <= 1'b0;
            busy <= 1'b0;
         end else begin
            MISO  <= shift[WIDTH-1];
            shift <= {shift[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
         end
      end
   end

   assign done = busy && (cnt == CW'(WIDTH));

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: MOSI frames to RAM din, RAM read word back out on MISO.
module spi_slave_if
   import spi_slave_pkg::*;
#(
   parameter int ADDR_WIDH = DEF_ADDR_WIDH,
   parameter int DATA_WIDH = DEF_DATA_WIDH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   SS_n,
   input  logic                   MOSI,
   output logic                   MISO,
   output logic [ADDR_WIDH+1:0]   rx_data,
   output logic                   rx_valid,
   input  logic [DATA_WIDH-1:0]   tx_data,
   input  logic                   tx_valid
);

   localparam int FW    = ADDR_WIDH + 2;
   localparam int CNT_W = $clog2(FW);

   spi_state_t       state;
   logic [FW-2:0]    shift_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic             frame_done;
   logic             tx_started;
   logic             rd_addr_rcvd;
   logic             tx_load;
   logic             tx_done;

   // One load per frame, and only once the read-data frame has been strobed out.
   assign tx_load = !SS_n && (state == READ_DATA) && frame_done && !tx_started && tx_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         frame_done   <= 1'b0;
         tx_started   <= 1'b0;
         rd_addr_rcvd <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            tx_started <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= CHK_CMD;
               CHK_CMD: begin
                  shift_reg <= {{(FW-2){1'b0}}, MOSI};
                  bit_cnt   <= CNT_W'(1);
                  if (!MOSI)             state <= WRITE;
                  else if (rd_addr_rcvd) state <= READ_DATA;
                  else                   state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!frame_done) begin
                     shift_reg <= {shift_reg[FW-3:0], MOSI};
                     bit_cnt   <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_W'(FW - 1)) begin
                        rx_data    <= {shift_reg, MOSI};
                        rx_valid   <= 1'b1;
                        frame_done <= 1'b1;
                        if (state == READ_ADD) rd_addr_rcvd <= 1'b1;
                     end
                  end else if (state == READ_DATA) begin
                     if (tx_load) tx_started   <= 1'b1;
                     if (tx_done) rd_addr_rcvd <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   spi_tx_shifter #(
      .WIDTH (DATA_WIDH)
   ) u_tx_shifter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tx_load),
      .clear (SS_n),
      .data  (tx_data),
      .MISO  (MISO),
      .done  (tx_done)
   );

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: edge-numbered transaction model plus literal frame/MISO checks.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   logic       check_en = 1'b0;
   logic       exp_rx_valid;
   logic       exp_miso;
   logic [9:0] exp_rx_data;
   bit         model_flag;
   logic [7:0] miso_word;

   always #5 clk = ~clk;

   spi_slave_if dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Outputs are compared on the falling edge, halfway between active edges.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rx_valid});
         check_output("rx_data", {22'd0, rx_data}, {22'd0, exp_rx_data});
         check_output("MISO", {31'd0, MISO}, {31'd0, exp_miso});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One SS_n-framed transaction; expectations are set by edge number E0..E21.
   task automatic apply_stimulus(input logic [9:0] frame, input logic [7:0] word,
                                 input int ss_abort, input int miso_abort, input int rst_at);
      int kind;
      kind = (frame[9] == 1'b0) ? 0 : (model_flag ? 2 : 1);
      tx_data   = word;
      miso_word = 8'h00;
      SS_n = 1'b0;
      tick();
      for (int k = 0; k < 10; k++) begin
         if (k == ss_abort) begin
            SS_n = 1'b1;
            tick();
            tick();
            return;
         end
         MOSI = frame[9-k];
         tick();
         if (k == 9) begin
            exp_rx_valid = 1'b1;
            exp_rx_data  = frame;
            if (kind == 1) model_flag = 1'b1;
         end
      end
      MOSI = ~frame[0];
      tick();
      exp_rx_valid = 1'b0;
      tx_valid = 1'b1;
      tick();
      for (int n = 0; n < 8; n++) begin
         if (kind == 2 && n == miso_abort) begin
            SS_n = 1'b1;
            tick();
            exp_miso = 1'b0;
            tx_valid = 1'b0;
            tick();
            return;
         end
         tick();
         if (kind == 2) exp_miso = word[7-n];
         miso_word = {miso_word[6:0], MISO};
         if (kind == 2 && n == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check_output("rst_MISO", {31'd0, MISO}, 32'd0);
            check_output("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
            exp_miso     = 1'b0;
            exp_rx_valid = 1'b0;
            exp_rx_data  = 10'h000;
            model_flag   = 1'b0;
            SS_n         = 1'b1;
            tx_valid     = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            return;
         end
      end
      tick();
      exp_miso = 1'b0;
      if (kind == 2) model_flag = 1'b0;
      tick();
      tick();
      tx_valid = 1'b0;
      SS_n = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      SS_n         = 1'b1;
      MOSI         = 1'b0;
      tx_valid     = 1'b0;
      tx_data      = 8'h00;
      exp_rx_valid = 1'b0;
      exp_miso     = 1'b0;
      exp_rx_data  = 10'h000;
      model_flag   = 1'b0;
      check_en     = 1'b1;
      #12;
      check_output("reset_MISO", {31'd0, MISO}, 32'd0);
      check_output("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_output("reset_rx_data", {22'd0, rx_data}, 32'd0);
      #10 rst_n = 1'b1;
      tick();
      tick();

      apply_stimulus(10'h005, 8'h00, -1, -1, -1);
      check_output("wr_addr_frame", {22'd0, rx_data}, 32'h005);
      apply_stimulus(10'h1A5, 8'h00, -1, -1, -1);
      check_output("wr_data_frame", {22'd0, rx_data}, 32'h1A5);

      apply_stimulus(10'h205, 8'h00, -1, -1, -1);
      check_output("rd_addr_frame", {22'd0, rx_data}, 32'h205);
      apply_stimulus(10'h3A7, 8'hC3, -1, -1, -1);
      check_output("rd_data_frame", {22'd0, rx_data}, 32'h3A7);
      check_output("rd_miso_word", {24'd0, miso_word}, 32'hC3);

      apply_stimulus(10'h2FF, 8'h00, 5, -1, -1);
      check_output("abort_keeps_rx_data", {22'd0, rx_data}, 32'h3A7);
      apply_stimulus(10'h101, 8'h00, -1, -1, -1);
      check_output("after_abort_frame", {22'd0, rx_data}, 32'h101);

      apply_stimulus(10'h205, 8'h00, -1, -1, -1);
      apply_stimulus(10'h3FF, 8'hA5, -1, 3, -1);
      apply_stimulus(10'h300, 8'h5A, -1, -1, -1);
      check_output("flag_kept_miso_word", {24'd0, miso_word}, 32'h5A);

      apply_stimulus(10'h200, 8'h00, -1, -1, -1);
      apply_stimulus(10'h3C0, 8'hFF, -1, -1, 3);
      check_output("post_reset_rx_data", {22'd0, rx_data}, 32'h000);
      apply_stimulus(10'h3C0, 8'h96, -1, -1, -1);
      check_output("post_reset_routes_rd_addr", {24'd0, miso_word}, 32'h00);
      apply_stimulus(10'h3C1, 8'h96, -1, -1, -1);
      check_output("post_reset_rd_data_word", {24'd0, miso_word}, 32'h96);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI slave subsystem: converts the MOSI bit stream into 10-bit command/address/data frames for the single-port RAM, and serialises the RAM's read word back out on MISO. It sits between the external SPI pins and the RAM's `din`/`rx_valid`/`dout`/`tx_valid` port. Mode 0 only: MOSI is sampled on the `clk` rising edge, and MISO is updated on the same edge.

## Interface
- `ADDR_WIDH`, 8: RAM address width. The frame width is `ADDR_WIDH+2`.
- `DATA_WIDH`, 8: RAM data width; this is the MISO word length.
- `clk`  in  1  system and SPI clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `SS_n`  in  1  slave select, active-low; frames the transaction.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first; 0 when not transmitting.
- `rx_data`  out  ADDR_WIDH+2  assembled frame to the RAM `din`.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid.
- `tx_data`  in  DATA_WIDH  read word from the RAM `dout`.
- `tx_valid`  in  1  RAM read word valid.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal flag `rd_addr_rcvd`.
- IDLE: on an edge with `SS_n`=0, go to CHK_CMD.
- CHK_CMD: the sampled MOSI is frame bit 9 (captured into the shift register).
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_rcvd`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_rcvd`=1 → READ_DATA.
- WRITE and READ_ADD:
  - Shift in the remaining 9 bits.
  - After the 10th bit, load `rx_data` and pulse `rx_valid` for one cycle.
  - READ_ADD also sets `rd_addr_rcvd`.
  - Then hold (ignore MOSI) until `SS_n`=1.
- READ_DATA:
  - Receive 10 bits and strobe them exactly as in WRITE.
  - Then wait for `tx_valid`=1. The edge that samples it loads `tx_data` into the TX shifter.
  - The next `DATA_WIDH` edges drive MISO with bits 7..0.
  - After the last bit, MISO returns to 0, `rd_addr_rcvd` clears, and the block holds until `SS_n`=1.
- Frame bits 9:8 are passed to the RAM unmodified; the block does not check them beyond routing on bit 9.
- `SS_n`=1 on any edge, from any state, returns the FSM to IDLE next cycle:
  - bit and TX counters clear;
  - any partial frame is discarded with no `rx_valid`;
  - MISO goes to 0;
  - `rd_addr_rcvd` is preserved.
- A new frame requires `SS_n` to go high and then low again.

## Timing
- Reset values:
  - FSM state IDLE;
  - `rx_data`=0, `rx_valid`=0, `MISO`=0;
  - `rd_addr_rcvd`=0;
  - counters 0.
- Edge numbering after `SS_n` falls:
  - E0 samples `SS_n`=0 (IDLE→CHK_CMD).
  - E1..E10 sample MOSI bits 9..0.
  - `rx_data` and `rx_valid`=1 are visible after E10, for exactly one cycle.
- Read latency: the RAM sees the frame after E10 and asserts `tx_valid` after E11.
  - With that RAM, `tx_data` is loaded at E12.
  - MISO carries bit 7 after E13 and bit 0 after E20.
  - Returns to 0 after E21.
- `tx_valid` held high for several cycles loads `tx_data` only once per frame.
- `tx_valid` seen outside READ_DATA after frame completion is ignored.
- `SS_n` rising mid-transmission truncates MISO immediately, and `rd_addr_rcvd` stays 1.
- Reset asserted mid-frame clears everything asynchronously, including `rd_addr_rcvd`.

## Structure
- Package `spi_slave_pkg` contains:
  - state enum `spi_state_t`;
  - `FRAME_W = ADDR_WIDH+2`;
  - command codes `CMD_WR_ADDR=2'b00`, `CMD_WR_DATA=2'b01`, `CMD_RD_ADDR=2'b10`, `CMD_RD_DATA=2'b11`.
- One sub-module: `spi_tx_shifter`, an 8-bit parallel-load, MSB-first serializer.
  - Inputs: `load`, `clear`.
  - Outputs: `MISO` and `done`.
- The FSM, RX shift register and bit counter stay in the top module.

## Test plan
- Write address: `SS_n` low, MOSI 00_0000_0101 → `rx_data`=10'h005 and a single `rx_valid` pulse after E10; MISO stays 0 throughout.
- Write data: MOSI 01_1010_0101 → `rx_data`=10'h1A5 with one `rx_valid` pulse; `rd_addr_rcvd` unchanged.
- Read sequence: frame 10_0000_0101 (routes READ_ADD, flag=1), then frame 11_xxxx_xxxx with a RAM model returning 8'hC3 on `tx_valid` → MISO serial 1,1,0,0,0,0,1,1 on E13..E20; flag clears.
- Abort: `SS_n` high after 5 MOSI bits → no `rx_valid` and FSM in IDLE next cycle; a following full frame 01_0000_0001 is received correctly.
- Reset mid-transmission: `rst_n` low while MISO is shifting 8'hFF → MISO=0 and `rx_valid`=0 immediately; a following read command routes to READ_ADD.
